// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the hazard controller: register/Tuse
// widths, forwarding select codes, the "operand not read" Tuse value and
// the saturating Tnew decrement used when a producer advances a stage.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int T_W   = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_M   = 2'd1;
    localparam logic [1:0] FWD_W   = 2'd2;

    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

    // Producer stages held by the scoreboard, nearest first.
    typedef enum logic [1:0] {
        STG_E = 2'd0,
        STG_M = 2'd1,
        STG_W = 2'd2
    } stage_e;

    // Forward select a consumer uses when the producer sits in stage stg.
    // E never forwards, so it maps to the plain GRF/latched path.
    function automatic logic [1:0] fwd_code(input int stg);
        logic [1:0] code;
        case (stg)
            int'(STG_M): code = FWD_M;
            int'(STG_W): code = FWD_W;
            default:     code = FWD_GRF;
        endcase
        return code;
    endfunction

    // Tnew counts down once per stage and holds at zero.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage hazard interface: the decoder side (master) presents the D
// instruction's operands, Tuse/Tnew and destination; the controller
// (slave) returns stall, forwarding selects and the stall counter.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic [T_W-1:0]   tuse_rs_d;
    logic [T_W-1:0]   tuse_rt_d;
    logic [T_W-1:0]   tnew_d;
    logic [REG_W-1:0] dst_d;

    logic             stall;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_rs_e;
    logic [1:0]       fwd_rt_e;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, tnew_d, dst_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall_cnt
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, tnew_d, dst_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// hazard_cmp: compares one consumer operand against one producer stage.
// stall_hit: producer writes the register and will not have it in time.
// fwd_hit:   producer writes the register and already holds the result.
// Register 0 never matches. FWD_EN=0 marks a stage that cannot forward.
module hazard_cmp
    import hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] reg_idx,
    input  logic [T_W-1:0]   tuse,
    input  logic [REG_W-1:0] dst,
    input  logic [T_W-1:0]   tnew,
    output logic             stall_hit,
    output logic             fwd_hit
);

    logic match;

    assign match     = (reg_idx != '0) && (reg_idx == dst);
    assign stall_hit = match && (tuse < tnew);
    assign fwd_hit   = FWD_EN && match && (tnew == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding controller for the 5-stage MIPS
// pipeline. Tracks an E/M/W scoreboard of destination register and
// remaining Tnew, stalls D when an operand is needed before its producer
// can supply it, and picks the nearest ready producer for forwarding.
// Optional macro HAZARD_STALL_CNT_EN builds a saturating stall counter;
// without it stall_cnt is tied to 0.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    hazard_ctrl_if.slave hif
);

    // Scoreboard state
    logic [REG_W-1:0] dst_e_reg, rs_e_reg, rt_e_reg;
    logic [T_W-1:0]   tnew_e_reg;
    logic [REG_W-1:0] dst_m_reg;
    logic [T_W-1:0]   tnew_m_reg;
    logic [REG_W-1:0] dst_w_reg;

    logic             stall;

    // Per-stage producer view, indexed by stage_e (W has no pending Tnew).
    logic [REG_W-1:0] stg_dst  [3];
    logic [T_W-1:0]   stg_tnew [3];

    assign stg_dst[0]  = dst_e_reg;
    assign stg_dst[1]  = dst_m_reg;
    assign stg_dst[2]  = dst_w_reg;
    assign stg_tnew[0] = tnew_e_reg;
    assign stg_tnew[1] = tnew_m_reg;
    assign stg_tnew[2] = '0;

    // Consumer operands: index 0 = rs, 1 = rt.
    logic [REG_W-1:0] d_reg  [2];
    logic [T_W-1:0]   d_tuse [2];
    logic [REG_W-1:0] e_reg  [2];

    assign d_reg[0]  = hif.rs_d;
    assign d_reg[1]  = hif.rt_d;
    assign d_tuse[0] = hif.tuse_rs_d;
    assign d_tuse[1] = hif.tuse_rt_d;
    assign e_reg[0]  = rs_e_reg;
    assign e_reg[1]  = rt_e_reg;

    logic [1:0][2:0] d_stall_hit, d_fwd_hit;
    logic [1:0][2:1] e_stall_hit, e_fwd_hit;

    for (genvar gi = 0; gi < 2; gi++) begin : g_op
        // D operand against E, M and W; E can stall but never forwards.
        for (genvar gs = 0; gs < 3; gs++) begin : g_d_stg
            hazard_cmp #(.FWD_EN(gs != 0)) u_cmp_d (
                .reg_idx   (d_reg[gi]),
                .tuse      (d_tuse[gi]),
                .dst       (stg_dst[gs]),
                .tnew      (stg_tnew[gs]),
                .stall_hit (d_stall_hit[gi][gs]),
                .fwd_hit   (d_fwd_hit[gi][gs])
            );
        end
        // E operand against M and W. The operand is already past its stall
        // point, so TUSE_NONE keeps these stall hits permanently low.
        for (genvar gs = 1; gs < 3; gs++) begin : g_e_stg
            hazard_cmp #(.FWD_EN(1'b1)) u_cmp_e (
                .reg_idx   (e_reg[gi]),
                .tuse      (TUSE_NONE),
                .dst       (stg_dst[gs]),
                .tnew      (stg_tnew[gs]),
                .stall_hit (e_stall_hit[gi][gs]),
                .fwd_hit   (e_fwd_hit[gi][gs])
            );
        end
    end

    // One stall regardless of how many operand/stage pairs collide.
    assign stall = (|d_stall_hit) | (|e_stall_hit);

    logic [1:0] d_sel [2];
    logic [1:0] e_sel [2];

    // Nearest ready producer wins: scan far to near, later hits override.
    always_comb begin
        for (int op = 0; op < 2; op++) begin
            d_sel[op] = FWD_GRF;
            e_sel[op] = FWD_GRF;
            for (int s = 2; s >= 0; s--) begin
                if (d_fwd_hit[op][s]) d_sel[op] = fwd_code(s);
            end
            for (int s = 2; s >= 1; s--) begin
                if (e_fwd_hit[op][s]) e_sel[op] = fwd_code(s);
            end
        end
    end

    assign hif.stall    = stall;
    assign hif.fwd_rs_d = d_sel[0];
    assign hif.fwd_rt_d = d_sel[1];
    assign hif.fwd_rs_e = e_sel[0];
    assign hif.fwd_rt_e = e_sel[1];

    // Scoreboard advance: D enters E unless stalled (then a bubble),
    // E moves to M with one Tnew step consumed, M moves to W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_e_reg  <= '0;
            tnew_e_reg <= '0;
            rs_e_reg   <= '0;
            rt_e_reg   <= '0;
            dst_m_reg  <= '0;
            tnew_m_reg <= '0;
            dst_w_reg  <= '0;
        end else begin
            if (stall) begin
                dst_e_reg  <= '0;
                tnew_e_reg <= '0;
                rs_e_reg   <= '0;
                rt_e_reg   <= '0;
            end else begin
                dst_e_reg  <= hif.dst_d;
                tnew_e_reg <= hif.tnew_d;
                rs_e_reg   <= hif.rs_d;
                rt_e_reg   <= hif.rt_d;
            end
            dst_m_reg  <= dst_e_reg;
            tnew_m_reg <= sat_dec(tnew_e_reg);
            dst_w_reg  <= dst_m_reg;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    // Count stalled cycles, holding at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign hif.stall_cnt = stall_cnt_reg;
`else
    assign hif.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed pipeline scenarios with hand-derived
// expectations, then randomized instruction streams checked against an
// age-based reference model of in-flight producers.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    int errors = 0;
    int checks = 0;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // Reference model: the last three instructions that entered E, by age
    // (0 = now in E, 1 = in M, 2 = in W), with the Tnew they had on entry.
    // Remaining Tnew at age k is simply max(tnew - k, 0).
    int h_dst [3];
    int h_tnew[3];
    int h_rs  [3];
    int h_rt  [3];
    int m_cnt;

    function automatic int rem(input int age);
        int r;
        r = h_tnew[age] - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit m_stall_op(input int r, input int tu);
        for (int age = 0; age < 2; age++) begin
            if (r != 0 && r == h_dst[age] && tu < rem(age)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return m_stall_op(int'(hif.rs_d), int'(hif.tuse_rs_d)) |
               m_stall_op(int'(hif.rt_d), int'(hif.tuse_rt_d));
    endfunction

    function automatic int m_fwd(input int r);
        if (r == 0) return 0;
        if (r == h_dst[1] && rem(1) == 0) return 1;
        if (r == h_dst[2]) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < 3; a++) begin
                h_dst[a] = 0; h_tnew[a] = 0; h_rs[a] = 0; h_rt[a] = 0;
            end
            m_cnt = 0;
        end else begin
            bit s;
            s = m_stall();
            for (int a = 2; a > 0; a--) begin
                h_dst[a] = h_dst[a-1]; h_tnew[a] = h_tnew[a-1];
                h_rs[a] = h_rs[a-1];   h_rt[a] = h_rt[a-1];
            end
            if (s) begin
                h_dst[0] = 0; h_tnew[0] = 0; h_rs[0] = 0; h_rt[0] = 0;
                m_cnt++;
            end else begin
                h_dst[0] = int'(hif.dst_d); h_tnew[0] = int'(hif.tnew_d);
                h_rs[0] = int'(hif.rs_d);   h_rt[0] = int'(hif.rt_d);
            end
        end
    end

    task automatic drive(input int rs, input int rt, input int tur,
                         input int tut, input int tn, input int dst);
        hif.rs_d      = REG_W'(rs);
        hif.rt_d      = REG_W'(rt);
        hif.tuse_rs_d = T_W'(tur);
        hif.tuse_rt_d = T_W'(tut);
        hif.tnew_d    = T_W'(tn);
        hif.dst_d     = REG_W'(dst);
    endtask

    task automatic nop();
        drive(0, 0, 3, 3, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) next_cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %0b want 0", hif.stall);
        end
        checks++;
        if ({hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e, hif.fwd_rt_e} !== 8'h00) begin
            errors++;
            $display("FAIL reset_fwd: got %h want 00",
                     {hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e, hif.fwd_rt_e});
        end
        checks++;
        if (hif.stall_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", hif.stall_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        flush();
        drive(0, 0, 3, 3, 2, 1);               // lw $1
        next_cycle();
        drive(1, 0, 1, 3, 1, 4);               // add $4,$1 (rs used in E)
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got %0b want 1", hif.stall);
        end
        next_cycle();                          // add held in D
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL load_use_release: got %0b want 0", hif.stall);
        end
        checks++;
        if (hif.fwd_rs_d !== FWD_GRF) begin
            errors++; $display("FAIL load_use_fwd_d: got %0d want 0", hif.fwd_rs_d);
        end
        next_cycle();
        nop();
        @(negedge clk);
        checks++;
        if (hif.fwd_rs_e !== FWD_W) begin
            errors++; $display("FAIL load_use_fwd_e: got %0d want 2", hif.fwd_rs_e);
        end
        $display("test_load_use done");
    endtask

    task automatic test_branch_fwd();
        flush();
        drive(0, 0, 3, 3, 1, 3);               // add $3
        next_cycle();
        drive(3, 0, 0, 3, 0, 0);               // beq $3 (compare in D)
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b1) begin
            errors++; $display("FAIL branch_stall: got %0b want 1", hif.stall);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL branch_release: got %0b want 0", hif.stall);
        end
        checks++;
        if (hif.fwd_rs_d !== FWD_M) begin
            errors++; $display("FAIL branch_fwd_m: got %0d want 1", hif.fwd_rs_d);
        end
        $display("test_branch_fwd done");
    endtask

    task automatic test_zero_reg();
        flush();
        drive(0, 0, 3, 3, 2, 0);               // writer to $0
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);               // reader of $0 in D
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL zero_stall: got %0b want 0", hif.stall);
        end
        checks++;
        if ({hif.fwd_rs_d, hif.fwd_rt_d} !== 4'h0) begin
            errors++;
            $display("FAIL zero_fwd_d: got %h want 0", {hif.fwd_rs_d, hif.fwd_rt_d});
        end
        next_cycle();
        nop();
        @(negedge clk);
        checks++;
        if ({hif.fwd_rs_e, hif.fwd_rt_e} !== 4'h0) begin
            errors++;
            $display("FAIL zero_fwd_e: got %h want 0", {hif.fwd_rs_e, hif.fwd_rt_e});
        end
        $display("test_zero_reg done");
    endtask

    task automatic test_back_to_back();
        flush();
        drive(0, 0, 1, 3, 1, 5);               // add $5
        next_cycle();
        drive(0, 0, 1, 3, 1, 5);               // ori $5
        next_cycle();
        drive(0, 5, 1, 2, 0, 0);               // sw, rt=$5 used in M
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL b2b_stall: got %0b want 0", hif.stall);
        end
        checks++;
        if (hif.fwd_rt_d !== FWD_M) begin
            errors++; $display("FAIL b2b_fwd_d: got %0d want 1", hif.fwd_rt_d);
        end
        next_cycle();
        nop();
        @(negedge clk);
        checks++;
        if (hif.fwd_rt_e !== FWD_M) begin
            errors++; $display("FAIL b2b_fwd_e: got %0d want 1", hif.fwd_rt_e);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        flush();
        drive(0, 0, 3, 3, 2, 1);               // lw $1
        next_cycle();
        drive(1, 0, 0, 3, 1, 2);               // beq-like reader of $1
        @(negedge clk);
        checks++;
        if (hif.stall !== 1'b1) begin
            errors++; $display("FAIL mid_pre_stall: got %0b want 1", hif.stall);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset_stall: got %0b want 0", hif.stall);
        end
        checks++;
        if (hif.stall_cnt !== '0) begin
            errors++; $display("FAIL mid_reset_cnt: got %0d want 0", hif.stall_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (hif.stall !== 1'b0) begin
            errors++; $display("FAIL mid_cleared: got %0b want 0", hif.stall);
        end
        next_cycle();
        $display("test_reset_mid done");
    endtask

    task automatic test_stall_cnt();
        flush();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 3, 3, 1, 7);           // add $7
            next_cycle();
            drive(7, 0, 0, 3, 0, 0);           // beq $7
            @(negedge clk);
            checks++;
            if (hif.stall !== 1'b1) begin
                errors++; $display("FAIL cnt_stall_%0d: got %0b want 1", k, hif.stall);
            end
            next_cycle();
            next_cycle();
            nop();
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (hif.stall_cnt !== (CNT_ON ? CNT_W'(3) : CNT_W'(0))) begin
            errors++;
            $display("FAIL stall_cnt3: got %0d want %0d", hif.stall_cnt, CNT_ON ? 3 : 0);
        end
        next_cycle();
        $display("test_stall_cnt done");
    endtask

    task automatic test_random();
        bit held;
        held = 1'b0;
        for (int t = 0; t < 200; t++) begin
            bit es;
            int ers, ert, eers, eert;
            if (!held) begin
                drive($urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), $urandom_range(0, 7));
            end
            @(negedge clk);
            es   = m_stall();
            ers  = m_fwd(int'(hif.rs_d));
            ert  = m_fwd(int'(hif.rt_d));
            eers = m_fwd(h_rs[0]);
            eert = m_fwd(h_rt[0]);
            $display("txn %0d rs=%0d rt=%0d tu=%0d/%0d tn=%0d dst=%0d stall=%0b fwd=%0d%0d%0d%0d",
                     t, hif.rs_d, hif.rt_d, hif.tuse_rs_d, hif.tuse_rt_d, hif.tnew_d,
                     hif.dst_d, hif.stall, hif.fwd_rs_d, hif.fwd_rt_d,
                     hif.fwd_rs_e, hif.fwd_rt_e);
            checks++;
            if (hif.stall !== es) begin
                errors++; $display("FAIL rnd_stall t=%0d: got %0b want %0b", t, hif.stall, es);
            end
            checks++;
            if (hif.fwd_rs_d !== 2'(ers)) begin
                errors++; $display("FAIL rnd_fwd_rs_d t=%0d: got %0d want %0d", t, hif.fwd_rs_d, ers);
            end
            checks++;
            if (hif.fwd_rt_d !== 2'(ert)) begin
                errors++; $display("FAIL rnd_fwd_rt_d t=%0d: got %0d want %0d", t, hif.fwd_rt_d, ert);
            end
            checks++;
            if (hif.fwd_rs_e !== 2'(eers)) begin
                errors++; $display("FAIL rnd_fwd_rs_e t=%0d: got %0d want %0d", t, hif.fwd_rs_e, eers);
            end
            checks++;
            if (hif.fwd_rt_e !== 2'(eert)) begin
                errors++; $display("FAIL rnd_fwd_rt_e t=%0d: got %0d want %0d", t, hif.fwd_rt_e, eert);
            end
            checks++;
            if (hif.stall_cnt !== (CNT_ON ? CNT_W'(m_cnt) : CNT_W'(0))) begin
                errors++;
                $display("FAIL rnd_cnt t=%0d: got %0d want %0d", t, hif.stall_cnt,
                         CNT_ON ? m_cnt : 0);
            end
            held = es;
            next_cycle();
        end
        $display("test_random done");
    endtask

    initial begin
        nop();
        reset = 1'b0;
        test_reset();
        reset = 1'b1;
        next_cycle();
        test_load_use();
        test_branch_fwd();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        test_stall_cnt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall and forwarding controller for the 5-stage MIPS pipeline.
- Consumes the D-stage decoder's Tuse_rs, Tuse_rt and Tnew, plus the D-stage destination register.
- Keeps its own E/M/W scoreboard of destination register and remaining Tnew, advanced every cycle.
- Produces the D stall/E bubble signal and the forwarding selects for the D-stage (beq/jr compare) and E-stage (ALU) operands.

Parameters:
- REG_W, 5, register-index width.
- T_W, 2, Tuse/Tnew width.
- CNT_W, 32, stall-counter width (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rs_d  input  REG_W  rs field of the instruction in D.
- rt_d  input  REG_W  rt field of the instruction in D.
- tuse_rs_d  input  T_W  Tuse for rs; 3 means rs is not read.
- tuse_rt_d  input  T_W  Tuse for rt; 3 means rt is not read.
- tnew_d  input  T_W  Tnew of the D instruction.
- dst_d  input  REG_W  destination register of the D instruction; 0 means no write.
- stall  output  1  freeze PC and F/D register, insert bubble into E.
- fwd_rs_d  output  2  select for the D-stage rs operand.
- fwd_rt_d  output  2  select for the D-stage rt operand.
- fwd_rs_e  output  2  select for the E-stage rs operand.
- fwd_rt_e  output  2  select for the E-stage rt operand.
- stall_cnt  output  CNT_W  stall-cycle count (see Optional Feature).
- Forward select codes: 0 = GRF/latched value, 1 = M result, 2 = W result.

Behaviour:
- Scoreboard state, one entry per stage:
  - E: dst_e, tnew_e, rs_e, rt_e.
  - M: dst_m, tnew_m.
  - W: dst_w.
- Reset (asynchronous, reset==0): all dst/rs/rt registers and tnew registers go to 0. Outputs are then stall=0, all fwd_*=0, stall_cnt=0. Reset asserted mid-operation discards all in-flight entries on the same edge.
- Every clock edge (reset==1):
  - E <= (stall ? bubble : {dst_d, tnew_d, rs_d, rt_d}). A bubble is dst=0, tnew=0, rs=0, rt=0.
  - M <= {dst_e, sat_dec(tnew_e)}.
  - W <= dst_m.
  - sat_dec(x) = (x==0) ? 0 : x-1. It never wraps below 0.
- stall (combinational, evaluated the same cycle):
  - stall_rs = (rs_d!=0) & ((rs_d==dst_e & tuse_rs_d<tnew_e) | (rs_d==dst_m & tuse_rs_d<tnew_m)).
  - stall_rt has the same form using rt_d and tuse_rt_d.
  - stall = stall_rs | stall_rt.
  - Tuse=3 can never be less than a legal Tnew (max 2), so it never stalls.
- fwd_rs_d / fwd_rt_d (combinational, register r = rs_d or rt_d):
  - r==0 → 0.
  - else r==dst_m & tnew_m==0 → 1.
  - else r==dst_w → 2.
  - else → 0.
  - M has priority over W (nearest producer wins).
  - A match in E is never forwarded to D; it either stalls or is already satisfied by a later stage.
- fwd_rs_e / fwd_rt_e: same rule using rs_e / rt_e.
- Register 0 never matches, even when dst=0 entries are present.
- Simultaneous rs and rt hazards produce a single stall, not two.
- A stall in one cycle clears on its own: the producer moves on to M/W, its Tnew drops, and the D instruction is held until the condition is false.
- All outputs except stall_cnt are combinational from scoreboard state and D inputs; the scoreboard has 1-cycle advance latency.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every clock edge where stall==1.
  - It saturates at all-ones and is cleared by reset.
- Undefined:
  - No counter register is built; stall_cnt is tied to 0.
  - All other behaviour is identical.

Decomposition:
- Shared constants header holds:
  - forward select codes (FWD_GRF=0, FWD_M=1, FWD_W=2);
  - TUSE_NONE=3;
  - the widths REG_W and T_W.
- One natural sub-module, hazard_cmp: given reg, tuse and one stage's {dst, tnew}, it returns stall_hit and fwd_hit. It is instantiated per operand/stage pair.

Test Plan:
- lw $1 in D (tnew_d=2, dst_d=1); next cycle add rs_d=1 with tuse_rs_d=1 → stall=1 for one cycle. On the following cycle dst_m=1, tnew_m=1, stall=0. One cycle later fwd_rs_e=2 (W).
- add $3 (tnew_d=1, dst_d=3), followed by beq rs_d=3, tuse_rs_d=0 → stall=1 for one cycle, then stall=0 with fwd_rs_d=1 (M, tnew_m=0).
- Writer to $0 (dst_d=0) followed by a reader of $0 with tuse=0 → stall=0, all fwd=0.
- add $5 then ori $5 back-to-back, then sw with rt_d=5 and tuse_rt_d=2 → no stall. fwd_rt_e selects M for the younger ori, never W for the older add.
- Stall in progress, then reset driven low mid-cycle → stall falls to 0 immediately and the scoreboard is cleared. With HAZARD_STALL_CNT_EN, stall_cnt=0.
- With HAZARD_STALL_CNT_EN, 3 independent single-cycle stalls → stall_cnt=3. Without the macro, stall_cnt stays 0.
